// File: rtl/cpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : cpu_pkg                                                    |
// | Description : Shared CPU constants and instruction-loader state encoding |
// |               used by imem_loader and imem_ram.                          |
// |   XLEN        datapath / instruction width                               |
// |   NOP_WORD    canonical NOP (addi x0,x0,0)                               |
// |   ldr_state_t loader FSM states                                          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // nothing loaded since reset
    ST_LOAD  = 2'd1,  // accepting instruction words
    ST_ARMED = 2'd2,  // program loaded, waiting for a start rising edge
    ST_RUN   = 2'd3   // core released
  } ldr_state_t;

  // Fetches are only served once a program is complete (armed or running).
  function automatic logic fetch_allowed(input ldr_state_t s);
    return (s == ST_ARMED) || (s == ST_RUN);
  endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/imem_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : imem_ram                                                   |
// | Description : DEPTH x WIDTH instruction storage. One synchronous write   |
// |               port and one registered read port. A read and a write to   |
// |               the same word on one edge return the previous contents.    |
// | Ports       :                                                            |
// |   clk    in   clock                                                      |
// |   we     in   write enable                                               |
// |   waddr  in   AW  write word index                                       |
// |   wdata  in   WIDTH write data                                           |
// |   re     in   read enable (rdata holds when low)                         |
// |   raddr  in   AW  read word index                                        |
// |   rdata  out  WIDTH registered read data                                 |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module imem_ram
  import cpu_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int WIDTH = XLEN,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Both assignments are non-blocking, so the read samples the array
  // before the write of the same edge lands: read-before-write.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= r_mem[raddr];
    end
  end

endmodule : imem_ram
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : imem_loader                                                |
// | Description : Receiving end of the CPU instruction-load interface.       |
// |               Captures words streamed on ins while load=1 into           |
// |               consecutive word addresses, releases the core with a       |
// |               one-cycle core_go pulse on a start rising edge, and serves |
// |               the core's fetches with one cycle of latency.              |
// | Ports       :                                                            |
// |   clk          in   system clock, rising edge                            |
// |   rst          in   asynchronous reset, active low                       |
// |   load         in   ins is written this cycle                            |
// |   ins          in   32  instruction word to store                        |
// |   start        in   run request, rising edge only                        |
// |   fetch_en     in   fetch request                                        |
// |   fetch_addr   in   32  byte address (PC)                                |
// |   fetch_ins    out  32  fetched word, registered                         |
// |   fetch_valid  out  fetch_ins valid this cycle                           |
// |   fetch_err    out  misaligned / out-of-range fetch                      |
// |   core_go      out  one-cycle core release pulse                         |
// |   running      out  core is released                                     |
// |   load_count   out  AW+1  words accepted this session, saturating        |
// |   overflow     out  sticky: a word arrived with the store full           |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module imem_loader
  import cpu_pkg::*;
#(
  parameter int              DEPTH    = 128,
  parameter logic [XLEN-1:0] NOP_WORD = cpu_pkg::NOP_WORD,
  localparam int             AW       = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [XLEN-1:0] ins,
  input  logic            start,
  input  logic            fetch_en,
  input  logic [XLEN-1:0] fetch_addr,
  output logic [XLEN-1:0] fetch_ins,
  output logic            fetch_valid,
  output logic            fetch_err,
  output logic            core_go,
  output logic            running,
  output logic [AW:0]     load_count,
  output logic            overflow
);

  localparam logic [AW:0]     C_DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [XLEN-3:0] C_DEPTH_IDX = (XLEN-2)'(DEPTH);

  // ------------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------------
  ldr_state_t       r_state;
  ldr_state_t       w_next;

  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_load_count;
  logic [DEPTH-1:0] r_valid;
  logic             r_start_q;
  logic             r_overflow;
  logic             r_running;
  logic             r_core_go;

  logic             r_fvalid;
  logic             r_ferr;
  logic             r_fhit;     // registered fetch will return RAM data

  // FSM decode outputs
  logic             w_new_session;
  logic             w_wr_en;
  logic [AW-1:0]    w_wr_addr;
  logic             w_drop;
  logic             w_go;

  // Fetch qualification
  logic             w_fetch_ok;
  logic             w_misalign;
  logic             w_oor;
  logic [AW-1:0]    w_fidx;
  logic [XLEN-1:0]  w_ram_rdata;

  // ------------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ------------------------------------------------------------------------
  // FSM: next state and per-edge control
  // ------------------------------------------------------------------------
  always_comb begin
    w_next        = r_state;
    w_new_session = 1'b0;
    w_wr_en       = 1'b0;
    w_wr_addr     = r_wr_ptr;
    w_drop        = 1'b0;
    w_go          = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        // start is ignored: nothing has been loaded yet.
        if (load) begin
          w_new_session = 1'b1;
        end
      end
      ST_LOAD: begin
        if (load) begin
          // Store is full: drop the word instead of wrapping over word 0.
          if (r_load_count == C_DEPTH_CNT) begin
            w_drop = 1'b1;
          end else begin
            w_wr_en = 1'b1;
          end
        end else begin
          w_next = ST_ARMED;
        end
      end
      ST_ARMED: begin
        // load takes priority over a coincident start edge.
        if (load) begin
          w_new_session = 1'b1;
        end else if (start && !r_start_q) begin
          w_go   = 1'b1;
          w_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (load) begin
          w_new_session = 1'b1;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase

    // Any new session writes its first word to index 0.
    if (w_new_session) begin
      w_next    = ST_LOAD;
      w_wr_en   = 1'b1;
      w_wr_addr = '0;
    end
  end

  // ------------------------------------------------------------------------
  // Load bookkeeping, start edge detect and run control
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr     <= '0;
      r_load_count <= '0;
      r_valid      <= '0;
      r_start_q    <= 1'b0;
      r_overflow   <= 1'b0;
      r_running    <= 1'b0;
      r_core_go    <= 1'b0;
    end else begin
      r_start_q <= start;
      r_core_go <= w_go;

      if (w_new_session) begin
        r_wr_ptr     <= AW'(1);
        r_load_count <= (AW+1)'(1);
        r_valid      <= {{(DEPTH-1){1'b0}}, 1'b1};
        r_overflow   <= 1'b0;
        r_running    <= 1'b0;
      end else begin
        if (w_wr_en) begin
          r_wr_ptr           <= r_wr_ptr + AW'(1);
          r_load_count       <= r_load_count + (AW+1)'(1);
          r_valid[w_wr_addr] <= 1'b1;
        end
        if (w_drop) begin
          r_overflow <= 1'b1;
        end
        if (w_go) begin
          r_running <= 1'b1;
        end
      end
    end
  end

  // ------------------------------------------------------------------------
  // Fetch path
  // ------------------------------------------------------------------------
  assign w_fetch_ok = fetch_en && fetch_allowed(r_state);
  assign w_misalign = (fetch_addr[1:0] != 2'b00);
  assign w_oor      = (fetch_addr[XLEN-1:2] >= C_DEPTH_IDX);
  assign w_fidx     = fetch_addr[AW+1:2];

  // Valid bits are sampled with the same edge as the RAM read, so a
  // coincident write is invisible to both (old contents, old valid).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fvalid <= 1'b0;
      r_ferr   <= 1'b0;
      r_fhit   <= 1'b0;
    end else begin
      r_fvalid <= w_fetch_ok;
      r_ferr   <= w_fetch_ok && (w_misalign || w_oor);
      r_fhit   <= w_fetch_ok && !w_misalign && !w_oor && r_valid[w_fidx];
    end
  end

  imem_ram #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN)
  ) u_ram (
    .clk   (clk),
    .we    (w_wr_en),
    .waddr (w_wr_addr),
    .wdata (ins),
    .re    (w_fetch_ok),
    .raddr (w_fidx),
    .rdata (w_ram_rdata)
  );

  // RAM data has no reset; r_fhit (reset low) masks it to NOP until a real
  // hit has been registered.
  assign fetch_ins   = r_fhit ? w_ram_rdata : NOP_WORD;
  assign fetch_valid = r_fvalid;
  assign fetch_err   = r_ferr;
  assign core_go     = r_core_go;
  assign running     = r_running;
  assign load_count  = r_load_count;
  assign overflow    = r_overflow;

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_imem_loader                                             |
// | Description : Directed self-checking bench for imem_loader.              |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_imem_loader;

  localparam int          DEPTH = 128;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [31:0] ins;
  logic        start;
  logic        fetch_en;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_ins;
  logic        fetch_valid;
  logic        fetch_err;
  logic        core_go;
  logic        running;
  logic [7:0]  load_count;
  logic        overflow;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] prog [4] = '{32'h0130_8093, 32'h0000_2103, 32'h0031_01B3, 32'h0010_0013};

  always #5 clk = ~clk;

  imem_loader dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .ins         (ins),
    .start       (start),
    .fetch_en    (fetch_en),
    .fetch_addr  (fetch_addr),
    .fetch_ins   (fetch_ins),
    .fetch_valid (fetch_valid),
    .fetch_err   (fetch_err),
    .core_go     (core_go),
    .running     (running),
    .load_count  (load_count),
    .overflow    (overflow)
  );

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; load = 1'b0; ins = '0; start = 1'b0; fetch_en = 1'b0; fetch_addr = '0;
    #2;
    n_vec++;
    if ({fetch_ins, fetch_valid, fetch_err} !== {NOP, 2'b00}) begin
      n_err++; $display("FAIL reset_fetch: got %h/%b/%b want %h/0/0", fetch_ins, fetch_valid, fetch_err, NOP);
    end
    n_vec++;
    if ({core_go, running, overflow, load_count} !== 11'd0) begin
      n_err++; $display("FAIL reset_ctrl: got go=%b run=%b ovf=%b cnt=%0d want all 0", core_go, running, overflow, load_count);
    end
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  // Test 1: load four words, start, fetch them back.
  task automatic test_load_run();
    logic [31:0] exp;
    load = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ins = prog[i];
      tick();
      n_vec++;
      if (load_count !== 8'(i + 1)) begin
        n_err++; $display("FAIL t1_count_%0d: got %0d want %0d", i, load_count, i + 1);
      end
    end
    load = 1'b0;
    tick();
    start = 1'b1;
    tick();
    n_vec++;
    if ({core_go, running} !== 2'b11) begin
      n_err++; $display("FAIL t1_go: got go=%b run=%b want 1/1", core_go, running);
    end
    tick();
    n_vec++;
    if ({core_go, running} !== 2'b01) begin
      n_err++; $display("FAIL t1_go_pulse: got go=%b run=%b want 0/1", core_go, running);
    end
    start = 1'b0;
    fetch_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      fetch_addr = 32'(i * 4);
      exp = (i < 4) ? prog[i] : NOP;
      tick();
      n_vec++;
      if ({fetch_valid, fetch_err, fetch_ins} !== {2'b10, exp}) begin
        n_err++; $display("FAIL t1_fetch_%0d: got v=%b e=%b %h want 1/0 %h", i, fetch_valid, fetch_err, fetch_ins, exp);
      end
    end
    fetch_en = 1'b0;
    tick();
    n_vec++;
    if (fetch_valid !== 1'b0) begin
      n_err++; $display("FAIL t1_fetch_idle: got valid=%b want 0", fetch_valid);
    end
  endtask

  // Test 5: misaligned / out-of-range fetches while running.
  task automatic test_bad_fetch();
    logic [31:0] addrs [3] = '{32'h0000_0002, 32'(4 * DEPTH), 32'hFFFF_FFFC};
    fetch_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_addr = addrs[i];
      tick();
      n_vec++;
      if ({fetch_valid, fetch_err, fetch_ins} !== {2'b11, NOP}) begin
        n_err++; $display("FAIL t5_bad_%0d: got v=%b e=%b %h want 1/1 %h", i, fetch_valid, fetch_err, fetch_ins, NOP);
      end
    end
    fetch_en = 1'b0;
    tick();
    n_vec++;
    if ({fetch_valid, fetch_err, running} !== 3'b001) begin
      n_err++; $display("FAIL t5_idle: got v=%b e=%b run=%b want 0/0/1", fetch_valid, fetch_err, running);
    end
  endtask

  // Test 4: abort a running program with a new one-word session.
  task automatic test_abort();
    fetch_en = 1'b1; fetch_addr = 32'h0;
    load = 1'b1; ins = 32'hDEAD_BEEF;
    tick();
    n_vec++;
    if ({running, load_count} !== {1'b0, 8'd1}) begin
      n_err++; $display("FAIL t4_abort: got run=%b cnt=%0d want 0/1", running, load_count);
    end
    // Fetch honoured in RUN on the abort edge sees the old word 0.
    n_vec++;
    if ({fetch_valid, fetch_ins} !== {1'b1, prog[0]}) begin
      n_err++; $display("FAIL t4_rbw: got v=%b %h want 1 %h", fetch_valid, fetch_ins, prog[0]);
    end
    load = 1'b0; fetch_en = 1'b0;
    tick();
    fetch_en = 1'b1; fetch_addr = 32'h0;
    tick();
    n_vec++;
    if ({fetch_valid, fetch_err, fetch_ins} !== {2'b10, 32'hDEAD_BEEF}) begin
      n_err++; $display("FAIL t4_word0: got v=%b e=%b %h want 1/0 deadbeef", fetch_valid, fetch_err, fetch_ins);
    end
    fetch_addr = 32'h4;
    tick();
    n_vec++;
    if ({fetch_valid, fetch_err, fetch_ins} !== {2'b10, NOP}) begin
      n_err++; $display("FAIL t4_word1: got v=%b e=%b %h want 1/0 %h", fetch_valid, fetch_err, fetch_ins, NOP);
    end
    fetch_en = 1'b0;
    tick();
  endtask

  // Test 3: start held through the load does not release the core.
  task automatic test_start_held();
    start = 1'b1; load = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ins = 32'h1111_0000 + 32'(i);
      tick();
      n_vec++;
      if (core_go !== 1'b0) begin
        n_err++; $display("FAIL t3_load_go_%0d: got %b want 0", i, core_go);
      end
    end
    load = 1'b0;
    tick();
    tick(); tick();
    n_vec++;
    if ({core_go, running, load_count} !== {2'b00, 8'd3}) begin
      n_err++; $display("FAIL t3_held: got go=%b run=%b cnt=%0d want 0/0/3", core_go, running, load_count);
    end
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    n_vec++;
    if ({core_go, running} !== 2'b11) begin
      n_err++; $display("FAIL t3_rise: got go=%b run=%b want 1/1", core_go, running);
    end
    tick();
    n_vec++;
    if (core_go !== 1'b0) begin
      n_err++; $display("FAIL t3_pulse: got %b want 0", core_go);
    end
    start = 1'b0;
  endtask

  // load and a start rise on the same edge in ARMED: load wins.
  task automatic test_load_wins();
    load = 1'b1; ins = 32'h0000_2222;
    tick();
    load = 1'b0;
    tick();
    load = 1'b1; start = 1'b1; ins = 32'h0000_3333;
    tick();
    n_vec++;
    if ({core_go, running, load_count} !== {2'b00, 8'd1}) begin
      n_err++; $display("FAIL lw_same_edge: got go=%b run=%b cnt=%0d want 0/0/1", core_go, running, load_count);
    end
    load = 1'b0;
    tick(); tick();
    n_vec++;
    if (core_go !== 1'b0) begin
      n_err++; $display("FAIL lw_stale_start: got %b want 0", core_go);
    end
    start = 1'b0;
    fetch_en = 1'b1; fetch_addr = 32'h0;
    tick();
    n_vec++;
    if (fetch_ins !== 32'h0000_3333) begin
      n_err++; $display("FAIL lw_word0: got %h want 00003333", fetch_ins);
    end
    fetch_en = 1'b0;
  endtask

  // Test 2: DEPTH+3 words saturate the counter and set overflow.
  task automatic test_overflow();
    load = 1'b1;
    for (int i = 0; i < DEPTH + 3; i++) begin
      ins = 32'hA000_0000 + 32'(i);
      tick();
      if (i == DEPTH - 1) begin
        n_vec++;
        if ({overflow, load_count} !== {1'b0, 8'(DEPTH)}) begin
          n_err++; $display("FAIL t2_full: got ovf=%b cnt=%0d want 0/%0d", overflow, load_count, DEPTH);
        end
      end
    end
    n_vec++;
    if ({overflow, load_count} !== {1'b1, 8'(DEPTH)}) begin
      n_err++; $display("FAIL t2_ovf: got ovf=%b cnt=%0d want 1/%0d", overflow, load_count, DEPTH);
    end
    load = 1'b0;
    tick();
    fetch_en = 1'b1; fetch_addr = 32'h0;
    tick();
    n_vec++;
    if ({fetch_err, fetch_ins} !== {1'b0, 32'hA000_0000}) begin
      n_err++; $display("FAIL t2_word0: got e=%b %h want 0 a0000000", fetch_err, fetch_ins);
    end
    fetch_addr = 32'(4 * (DEPTH - 1));
    tick();
    n_vec++;
    if ({fetch_err, fetch_ins} !== {1'b0, 32'hA000_007F}) begin
      n_err++; $display("FAIL t2_last: got e=%b %h want 0 a000007f", fetch_err, fetch_ins);
    end
    fetch_en = 1'b0;
    tick();
    n_vec++;
    if (overflow !== 1'b1) begin
      n_err++; $display("FAIL t2_sticky: got %b want 1", overflow);
    end
  endtask

  // Test 6: asynchronous reset mid-load.
  task automatic test_async_reset();
    load = 1'b1; ins = 32'h5555_0000;
    tick();
    ins = 32'h5555_0001;
    tick();
    n_vec++;
    if (load_count !== 8'd2) begin
      n_err++; $display("FAIL t6_pre: got cnt=%0d want 2", load_count);
    end
    #2;
    rst = 1'b0;
    #1;
    n_vec++;
    if ({load_count, overflow, running, core_go, fetch_valid, fetch_err, fetch_ins} !== {8'd0, 6'd0, NOP}) begin
      n_err++; $display("FAIL t6_async: got cnt=%0d ovf=%b run=%b go=%b v=%b e=%b %h want all 0 / %h",
                        load_count, overflow, running, core_go, fetch_valid, fetch_err, fetch_ins, NOP);
    end
    load = 1'b0;
    tick();
    rst = 1'b1;
    start = 1'b1; fetch_en = 1'b1; fetch_addr = 32'h0;
    tick();
    n_vec++;
    if ({core_go, running, fetch_valid, fetch_err, fetch_ins} !== {4'b0000, NOP}) begin
      n_err++; $display("FAIL t6_idle: got go=%b run=%b v=%b e=%b %h want 0/0/0/0 %h",
                        core_go, running, fetch_valid, fetch_err, fetch_ins, NOP);
    end
    start = 1'b0; fetch_en = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_load_run();
    test_bad_fetch();
    test_abort();
    test_start_held();
    test_load_wins();
    test_overflow();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion want finish before 200000 ns");
    $fatal(1, "timeout");
  end

endmodule : tb_imem_loader
`default_nettype wire
